// File: rtl/reg_file.sv
// rtl/reg_file.sv - register file with post-reset clear sweep, x0 hardwired to zero; optional write-through via REG_FILE_BYPASS_EN
module reg_file #(
    parameter int XLEN = 32,
    parameter int NREG = 32
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     we,
    input  logic [$clog2(NREG)-1:0]  waddr,
    input  logic [XLEN-1:0]          wdata,
    input  logic [$clog2(NREG)-1:0]  raddr1,
    input  logic [$clog2(NREG)-1:0]  raddr2,
    output logic [XLEN-1:0]          rdata1,
    output logic [XLEN-1:0]          rdata2,
    output logic                     ready
);

    localparam int AW = $clog2(NREG);
    localparam logic [AW-1:0] LAST = AW'(NREG - 1);

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } state_t;

    state_t          state;
    state_t          state_nx;
    logic [AW-1:0]   cnt;
    logic [AW-1:0]   cnt_nx;

    // Entry 0 is never written; reads of index 0 are forced to zero instead.
    logic [XLEN-1:0] regs [NREG];

    // Next-state logic: the sweep walks cnt from 1 to NREG-1, then hands over to RUN.
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        case (state)
            CLEAR: begin
                cnt_nx = cnt + AW'(1);
                if (cnt == LAST) begin
                    state_nx = RUN;
                end
            end
            RUN: begin
                state_nx = RUN;
            end
            default: begin
                state_nx = CLEAR;
            end
        endcase
    end

    // State, sweep counter and ready flop; ready is loaded from the next state so it is a clean register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= CLEAR;
            cnt   <= AW'(1);
            ready <= 1'b0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            ready <= (state_nx == RUN);
        end
    end

    // Array update: sweep zeroes one entry per cycle in CLEAR, user writes only land in RUN.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            if (state == CLEAR) begin
                if (cnt != '0) begin
                    regs[cnt] <= '0;
                end
            end else if (we && (waddr != '0)) begin
                regs[waddr] <= wdata;
            end
        end
    end

    // Read port 1: zero during reset/CLEAR and for x0, optional same-cycle write-through.
    always_comb begin
        rdata1 = '0;
        if (ready && rst_n && (raddr1 != '0)) begin
            rdata1 = regs[raddr1];
`ifdef REG_FILE_BYPASS_EN
            if (we && (waddr == raddr1)) begin
                rdata1 = wdata;
            end
`endif
        end
    end

    // Read port 2: identical behaviour to port 1, independently addressed.
    always_comb begin
        rdata2 = '0;
        if (ready && rst_n && (raddr2 != '0)) begin
            rdata2 = regs[raddr2];
`ifdef REG_FILE_BYPASS_EN
            if (we && (waddr == raddr2)) begin
                rdata2 = wdata;
            end
`endif
        end
    end

endmodule

// File: tb/tb_reg_file.sv
// tb/tb_reg_file.sv - scoreboard bench for reg_file with randomized stimulus and a behavioural model
module tb_reg_file;

    localparam int XLEN = 32;
    localparam int NREG = 32;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            we;
    logic [4:0]      waddr;
    logic [31:0]     wdata;
    logic [4:0]      raddr1;
    logic [4:0]      raddr2;
    logic [31:0]     rdata1;
    logic [31:0]     rdata2;
    logic            ready;

    reg_file #(.XLEN(XLEN), .NREG(NREG)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .we     (we),
        .waddr  (waddr),
        .wdata  (wdata),
        .raddr1 (raddr1),
        .raddr2 (raddr2),
        .rdata1 (rdata1),
        .rdata2 (rdata2),
        .ready  (ready)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rdy;
        logic [31:0] d1;
        logic [31:0] d2;
        logic [4:0]  a1;
        logic [4:0]  a2;
    } exp_t;

    exp_t        sb [$];
    int          tests = 0;
    int          fails = 0;

    // Reference model: contents plus how many sweep edges remain before ready.
    logic [31:0] m_regs [NREG];
    logic        m_ready = 1'b0;
    int          m_left  = NREG - 1;

    function automatic logic [31:0] model_read(input logic [4:0] ra, input logic r,
                                               input logic w, input logic [4:0] wa,
                                               input logic [31:0] wd);
        if (!r || !m_ready || ra == 5'd0) return 32'd0;
`ifdef REG_FILE_BYPASS_EN
        if (w && wa == ra) return wd;
`endif
        return m_regs[ra];
    endfunction

    task automatic step(input logic r, input logic w, input logic [4:0] wa,
                        input logic [31:0] wd, input logic [4:0] a1, input logic [4:0] a2);
        exp_t e;
        @(negedge clk);
        rst_n = r; we = w; waddr = wa; wdata = wd; raddr1 = a1; raddr2 = a2;
        #1;
        e.rdy = m_ready;
        e.a1  = a1;
        e.a2  = a2;
        e.d1  = model_read(a1, r, w, wa, wd);
        e.d2  = model_read(a2, r, w, wa, wd);
        sb.push_back(e);
        if (!r) begin
            m_ready = 1'b0;
            m_left  = NREG - 1;
        end else if (!m_ready) begin
            m_left = m_left - 1;
            if (m_left == 0) begin
                m_ready = 1'b1;
                for (int i = 0; i < NREG; i++) m_regs[i] = 32'd0;
            end
        end else if (w && wa != 5'd0) begin
            m_regs[wa] = wd;
        end
    endtask

    task automatic rand_step(input int reset_odds);
        logic [4:0] wa;
        logic [4:0] a1;
        logic [4:0] a2;
        wa = 5'($urandom_range(0, 31));
        a1 = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom_range(0, 31));
        a2 = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom_range(0, 31));
        step((reset_odds == 0) ? 1'b1 : ($urandom_range(0, reset_odds - 1) != 0),
             1'($urandom_range(0, 1)), wa, $urandom, a1, a2);
    endtask

    // Monitor: after inputs settle, pop pending expectations and compare against the live outputs.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #3;
            while (sb.size() > 0) begin
                e = sb.pop_front();
                tests++;
                if (ready !== e.rdy) begin
                    fails++;
                    $display("FAIL ready: got %b expected %b", ready, e.rdy);
                end
                tests++;
                if (rdata1 !== e.d1) begin
                    fails++;
                    $display("FAIL rdata1[x%0d]: got %h expected %h", e.a1, rdata1, e.d1);
                end
                tests++;
                if (rdata2 !== e.d2) begin
                    fails++;
                    $display("FAIL rdata2[x%0d]: got %h expected %h", e.a2, rdata2, e.d2);
                end
            end
        end
    end

    initial begin
        rst_n = 1'b0; we = 1'b0; waddr = '0; wdata = '0; raddr1 = '0; raddr2 = '0;
        for (int i = 0; i < NREG; i++) m_regs[i] = 32'hBAD0_0000 | i;
        @(posedge clk);

        // Reset held two cycles, then a full sweep with a stray write to x3 at sweep cycle 10.
        step(1'b0, 1'b1, 5'd9, 32'h1111_2222, 5'd9, 5'd3);
        step(1'b0, 1'b0, 5'd0, 32'h0, 5'd31, 5'd1);
        for (int c = 1; c <= NREG - 1; c++) begin
            if (c == 10) step(1'b1, 1'b1, 5'd3, 32'hA5A5_A5A5, 5'd3, 5'd3);
            else         step(1'b1, 1'b1, 5'($urandom_range(0, 31)), $urandom,
                              5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
        end
        for (int i = 0; i < NREG; i += 2) step(1'b1, 1'b0, 5'd0, 32'h0, 5'(i), 5'(i + 1));

        // Directed write/read, x0 protection and same-cycle hazard.
        step(1'b1, 1'b1, 5'd5, 32'hDEAD_BEEF, 5'd1, 5'd2);
        step(1'b1, 1'b0, 5'd0, 32'h0, 5'd5, 5'd5);
        step(1'b1, 1'b1, 5'd0, 32'hFFFF_FFFF, 5'd0, 5'd0);
        step(1'b1, 1'b0, 5'd0, 32'h0, 5'd0, 5'd5);
        step(1'b1, 1'b1, 5'd7, 32'h1234_5678, 5'd3, 5'd7);
        step(1'b1, 1'b0, 5'd0, 32'h0, 5'd7, 5'd7);

        for (int i = 0; i < 300; i++) rand_step(0);

        // Fill x1..x31 with their index, pulse reset mid-run, check the sweep wipes everything.
        for (int i = 1; i < NREG; i++) step(1'b1, 1'b1, 5'(i), 32'(i), 5'(i), 5'(i - 1));
        step(1'b0, 1'b0, 5'd0, 32'h0, 5'd4, 5'd9);
        for (int c = 1; c <= NREG - 1; c++) step(1'b1, 1'b0, 5'd0, 32'h0, 5'(c), 5'(NREG - c));
        for (int i = 0; i < NREG; i += 2) step(1'b1, 1'b0, 5'd0, 32'h0, 5'(i + 1), 5'(i));

        // Random traffic with occasional resets landing mid-sweep and in RUN.
        for (int i = 0; i < 600; i++) rand_step(48);
        for (int i = 0; i < 40; i++) rand_step(0);

        @(negedge clk);
        #5;
        tests++;
        if (sb.size() != 0) begin
            fails++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
